// File: rtl/peri_dbus_arbiter_pkg.sv
// Shared types for the peripheral data-bus arbiter: bus structs, FSM state
// encoding, timeout completion data and per-master index width.
`ifndef PERI_ARB_IDX_W
`define PERI_ARB_IDX_W 2
`endif

package peri_arb_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } type_arb_state_e;

  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Wide enough for up to four masters.
  localparam int ARB_IDX_W = `PERI_ARB_IDX_W;

endpackage

// File: rtl/peri_dbus_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester found searching upward
// from last_gnt+1 (modulo NUM_MASTERS) wins.
module rr_pick
  import peri_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ARB_IDX_W-1:0]   last_gnt,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic                   valid
);

  // Priority rotates so the most recently served master is searched last.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!valid && req[k] && (((int'(last_gnt) + off) % NUM_MASTERS) == k)) begin
          gnt[k] = 1'b1;
          valid  = 1'b1;
        end else begin
          gnt[k] = gnt[k];
        end
      end
    end
  end

endmodule

// File: rtl/peri_dbus_arbiter.sv
// Round-robin arbiter sharing the peripheral data bus between NUM_MASTERS masters.
// Optional BUSY watchdog with error completion enabled by PERI_ARB_TIMEOUT_EN.
module peri_dbus_arbiter
  import peri_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2
`ifdef PERI_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  type_dbus2peri_s        m_dbus_i [NUM_MASTERS],
  output type_peri2dbus_s        m_dbus_o [NUM_MASTERS],
  output type_dbus2peri_s        dbus2peri_o,
  input  type_peri2dbus_s        peri2dbus_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic                   busy_o
`ifdef PERI_ARB_TIMEOUT_EN
  , output logic                 timeout_o
`endif
);

  type_arb_state_e        state, state_next;
  logic [NUM_MASTERS-1:0] gnt_ff, gnt_next;
  logic [ARB_IDX_W-1:0]   last_gnt, last_gnt_next;
  logic [NUM_MASTERS-1:0] req_vec;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  type_dbus2peri_s        sel_req;
  logic [ARB_IDX_W-1:0]   sel_idx;
  type_peri2dbus_s        resp;
  logic                   tmo_hit;

  // Gather request bits and mux the granted master's request.
  always_comb begin
    req_vec = '0;
    sel_req = '0;
    sel_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      req_vec[k] = m_dbus_i[k].req;
      sel_req    = gnt_ff[k] ? m_dbus_i[k] : sel_req;
      sel_idx    = gnt_ff[k] ? ARB_IDX_W'(k) : sel_idx;
    end
  end

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr_pick (
    .req     (req_vec),
    .last_gnt(last_gnt),
    .gnt     (pick_gnt),
    .valid   (pick_valid)
  );

`ifdef PERI_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_ff;

  // Watchdog fires only when no ack and no abort compete in the same cycle.
  always_comb begin
    tmo_hit = (state == ARB_BUSY) && sel_req.req && !peri2dbus_i.ack &&
              (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  end

  // BUSY cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
      tmo_ff  <= 1'b0;
    end else begin
      if ((state == ARB_BUSY) && !peri2dbus_i.ack) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end else begin
        tmo_cnt <= 8'd0;
      end
      if (tmo_hit) begin
        tmo_ff <= 1'b1;
      end else begin
        tmo_ff <= tmo_ff;
      end
    end
  end

  assign timeout_o = tmo_ff;
`else
  // Without the watchdog BUSY waits indefinitely for ack.
  always_comb begin
    tmo_hit = 1'b0;
  end
`endif

  // Next-state logic and the combinational request/response routing.
  always_comb begin
    state_next    = state;
    gnt_next      = gnt_ff;
    last_gnt_next = last_gnt;
    dbus2peri_o   = '0;
    resp          = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      m_dbus_o[k] = '0;
    end
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_next   = pick_gnt;
          state_next = ARB_BUSY;
        end else begin
          gnt_next   = '0;
          state_next = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        dbus2peri_o = sel_req;
        if (tmo_hit) begin
          resp.r_data = ARB_TIMEOUT_RDATA;
          resp.ack    = 1'b1;
        end else begin
          resp = peri2dbus_i;
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
          m_dbus_o[k] = gnt_ff[k] ? resp : '0;
        end
        // Ack, abort (req dropped) and timeout all close the grant.
        if (peri2dbus_i.ack || !sel_req.req || tmo_hit) begin
          state_next    = ARB_IDLE;
          gnt_next      = '0;
          last_gnt_next = sel_idx;
        end else begin
          state_next = ARB_BUSY;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      gnt_ff   <= '0;
      last_gnt <= ARB_IDX_W'(NUM_MASTERS - 1);
    end else begin
      state    <= state_next;
      gnt_ff   <= gnt_next;
      last_gnt <= last_gnt_next;
    end
  end

  assign gnt_o  = gnt_ff;
  assign busy_o = (state == ARB_BUSY);

endmodule

// File: tb/tb_peri_dbus_arbiter.sv
// Self-checking bench for peri_dbus_arbiter with a gpio-style registered-ack
// peripheral model and an ack scoreboard; timeout test needs PERI_ARB_TIMEOUT_EN.
module tb_peri_dbus_arbiter;
  import peri_arb_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  type_dbus2peri_s m_req [2];
  type_peri2dbus_s m_rsp [2];
  type_dbus2peri_s p_req;
  type_peri2dbus_s p_rsp = '0;
  logic [1:0]      gnt;
  logic            busy;
  logic            mute = 1'b0;
`ifdef PERI_ARB_TIMEOUT_EN
  logic            tmo;
`endif

  typedef struct {
    int          master;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  peri_dbus_arbiter #(
    .NUM_MASTERS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_dbus_i   (m_req),
    .m_dbus_o   (m_rsp),
    .dbus2peri_o(p_req),
    .peri2dbus_i(p_rsp),
    .gnt_o      (gnt),
    .busy_o     (busy)
`ifdef PERI_ARB_TIMEOUT_EN
    , .timeout_o(tmo)
`endif
  );

  always #5 clk = ~clk;

  // Peripheral model: ack and read data registered one cycle after req.
  always @(posedge clk) begin
    p_rsp.ack    <= p_req.req && !mute;
    p_rsp.r_data <= 32'h0000_00A5 + p_req.addr;
  end

  // Scoreboard: every ack reaching a master must match the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_rsp[k].ack === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_ack master=%0d got ack r_data=%h, expected no ack", k, m_rsp[k].r_data);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.master != k || m_rsp[k].r_data !== mon_e.rdata) begin
            n_err++;
            $display("FAIL sb_ack got master=%0d r_data=%h, expected master=%0d r_data=%h",
                     k, m_rsp[k].r_data, mon_e.master, mon_e.rdata);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input int master, input logic [31:0] rdata);
    exp_t e;
    e.master = master;
    e.rdata  = rdata;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    m_req[0]        = '0;
    m_req[1]        = '0;
    m_req[0].addr   = 32'h44;
    m_req[0].w_data = 32'h55;
    m_req[0].req    = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 2'b00); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
    n_cmp++;
    if (p_req !== '0) begin n_err++; $display("FAIL reset_dbus2peri got=%h exp=0", p_req); end
    n_cmp++;
    if (m_rsp[0] !== '0 || m_rsp[1] !== '0) begin
      n_err++; $display("FAIL reset_m_dbus_o got=%h/%h exp=0/0", m_rsp[0], m_rsp[1]);
    end
    m_req[0] = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    m_req[0].addr = 32'h0;
    m_req[0].req  = 1'b1;
    push(0, 32'h0000_00A5);
    tick();
    n_cmp++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      n_err++; $display("FAIL single_c1_gnt got gnt=%b busy=%b exp gnt=01 busy=1", gnt, busy);
    end
    n_cmp++;
    if (p_req.req !== 1'b1 || p_req.addr !== 32'h0) begin
      n_err++; $display("FAIL single_c1_fwd got req=%b addr=%h exp req=1 addr=0", p_req.req, p_req.addr);
    end
    tick();
    n_cmp++;
    if (gnt !== 2'b01 || m_rsp[0].ack !== 1'b1 || m_rsp[0].r_data !== 32'h0000_00A5) begin
      n_err++; $display("FAIL single_c2_ack got gnt=%b ack=%b r_data=%h exp gnt=01 ack=1 r_data=000000a5",
                        gnt, m_rsp[0].ack, m_rsp[0].r_data);
    end
    n_cmp++;
    if (m_rsp[1].ack !== 1'b0) begin n_err++; $display("FAIL single_m1_ack got=%b exp=0", m_rsp[1].ack); end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || gnt !== 2'b00 || p_req.req !== 1'b0) begin
      n_err++; $display("FAIL single_c3_idle got busy=%b gnt=%b req=%b exp 0/00/0", busy, gnt, p_req.req);
    end
    m_req[0].req = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt [3];
    exp_gnt[0] = 2'b01;
    exp_gnt[1] = 2'b10;
    exp_gnt[2] = 2'b01;
    do_reset();
    m_req[0].addr = 32'h10;
    m_req[1].addr = 32'h20;
    m_req[0].req  = 1'b1;
    m_req[1].req  = 1'b1;
    push(0, 32'h0000_00B5);
    push(1, 32'h0000_00C5);
    push(0, 32'h0000_00B5);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (gnt !== exp_gnt[i] || busy !== 1'b1) begin
        n_err++; $display("FAIL contention_gnt%0d got gnt=%b busy=%b exp gnt=%b busy=1", i, gnt, busy, exp_gnt[i]);
      end
      tick();
      n_cmp++;
      if (gnt !== exp_gnt[i]) begin
        n_err++; $display("FAIL contention_hold%0d got gnt=%b exp=%b", i, gnt, exp_gnt[i]);
      end
      tick();
      n_cmp++;
      if (gnt !== 2'b00 || p_req.req !== 1'b0) begin
        n_err++; $display("FAIL contention_gap%0d got gnt=%b req=%b exp gnt=00 req=0", i, gnt, p_req.req);
      end
    end
    m_req[0].req = 1'b0;
    m_req[1].req = 1'b0;
  endtask

  task automatic test_back_to_back();
    m_req[1].addr   = 32'h8;
    m_req[1].w_data = 32'h3C;
    m_req[1].w_en   = 1'b1;
    m_req[1].req    = 1'b1;
    push(1, 32'h0000_00AD);
    push(1, 32'h0000_00AD);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (gnt !== 2'b10 || p_req.w_data !== 32'h3C || p_req.w_en !== 1'b1 || p_req.req !== 1'b1) begin
        n_err++; $display("FAIL b2b_fwd%0d got gnt=%b w_data=%h w_en=%b req=%b exp 10/0000003c/1/1",
                          i, gnt, p_req.w_data, p_req.w_en, p_req.req);
      end
      tick();
      tick();
      n_cmp++;
      if (busy !== 1'b0 || p_req.req !== 1'b0) begin
        n_err++; $display("FAIL b2b_gap%0d got busy=%b req=%b exp 0/0", i, busy, p_req.req);
      end
    end
    m_req[1] = '0;
  endtask

  task automatic test_abort();
    do_reset();
    m_req[0].addr = 32'h50;
    m_req[1].addr = 32'h60;
    m_req[0].req  = 1'b1;
    m_req[1].req  = 1'b1;
    push(1, 32'h0000_0105);
    tick();
    n_cmp++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL abort_gnt0 got=%b exp=01", gnt); end
    m_req[0].req = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || gnt !== 2'b00 || m_rsp[0].ack !== 1'b0) begin
      n_err++; $display("FAIL abort_idle got busy=%b gnt=%b ack0=%b exp 0/00/0", busy, gnt, m_rsp[0].ack);
    end
    tick();
    n_cmp++;
    if (gnt !== 2'b10) begin n_err++; $display("FAIL abort_gnt1 got=%b exp=10", gnt); end
    tick();
    n_cmp++;
    if (m_rsp[1].ack !== 1'b1) begin n_err++; $display("FAIL abort_m1_ack got=%b exp=1", m_rsp[1].ack); end
    tick();
    m_req[1].req = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    m_req[0].addr = 32'h30;
    m_req[0].req  = 1'b1;
    push(0, 32'h0000_00D5);
    tick();
    tick();
    tick();
    m_req[0].req = 1'b0;
    tick();
    m_req[0].req = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL rstmid_gnt got=%b exp=01", gnt); end
    m_req[1].addr = 32'h40;
    m_req[1].req  = 1'b1;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 2'b00 || busy !== 1'b0 || p_req.req !== 1'b0 || m_rsp[0].ack !== 1'b0) begin
      n_err++; $display("FAIL rstmid_drop got gnt=%b busy=%b req=%b ack0=%b exp 00/0/0/0",
                        gnt, busy, p_req.req, m_rsp[0].ack);
    end
    rst = 1'b0;
    push(0, 32'h0000_00D5);
    tick();
    n_cmp++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL rstmid_regrant got=%b exp=01", gnt); end
    tick();
    tick();
    m_req[0].req = 1'b0;
    m_req[1].req = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_end got busy=%b exp=0", busy); end
  endtask

`ifdef PERI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    do_reset();
    mute          = 1'b1;
    m_req[0].addr = 32'h70;
    m_req[0].req  = 1'b1;
    push(0, 32'hDEAD_BEEF);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (m_rsp[0].ack !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin n_err++; $display("FAIL tmo_early got %0d early acks exp 0", early); end
    tick();
    n_cmp++;
    if (m_rsp[0].ack !== 1'b1 || m_rsp[0].r_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL tmo_ack got ack=%b r_data=%h exp 1/deadbeef", m_rsp[0].ack, m_rsp[0].r_data);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || tmo !== 1'b1) begin
      n_err++; $display("FAIL tmo_flag got busy=%b timeout=%b exp 0/1", busy, tmo);
    end
    m_req[0].req = 1'b0;
    mute = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (tmo !== 1'b1) begin n_err++; $display("FAIL tmo_sticky got=%b exp=1", tmo); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_abort();
    test_reset_mid_busy();
`ifdef PERI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_drain got %0d outstanding expectations exp 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
